// File: rtl/pattern_merge_bist_ctrl.sv
// BIST sequencer: resets the pattern netlist, drives LFSR vectors, compacts responses into a MISR.
// Optional signature comparator enabled by defining PMG_SIG_COMPARE_EN.
module pattern_merge_bist_ctrl #(
   parameter int          IN_W         = 11,
   parameter int          OUT_W        = 10,
   parameter int          NUM_PATTERNS = 256,
   parameter int          DUT_LAT      = 2,
   parameter int          RST_CYC      = 2,
   parameter logic [15:0] SEED         = 16'hACE1,
   parameter logic [15:0] GOLDEN_SIG   = 16'h0000
) (
   input  logic             blif_clk_net,
   input  logic             blif_reset_net,
   input  logic             start,
   input  logic             abort,
   output logic             dut_rst_n,
   output logic [IN_W-1:0]  dut_in,
   input  logic [OUT_W-1:0] dut_out,
   output logic             busy,
   output logic             done,
   output logic [15:0]      sig,
   output logic             pass
);

   localparam int PC_W   = $clog2(NUM_PATTERNS + 1);
   localparam int CC_MAX = (RST_CYC > DUT_LAT) ? RST_CYC : DUT_LAT;
   localparam int CC_W   = $clog2(CC_MAX + 1);

   typedef enum logic [2:0] {IDLE, RSTD, RUN, DRAIN, DONE} state_t;

   state_t            state, state_nxt;
   logic [15:0]       lfsr, misr, misr_nxt;
   logic [PC_W-1:0]   pat_cnt, pat_nxt;
   logic [CC_W-1:0]   cyc_cnt;
   logic [DUT_LAT:1]  vld_pipe;
   logic              lfsr_fb, misr_fb, active, abort_hit, capture;

   assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
   assign misr_fb   = misr[15] ^ misr[13] ^ misr[12] ^ misr[10];
   assign misr_nxt  = {misr[14:0], misr_fb} ^ 16'(dut_out);
   assign pat_nxt   = pat_cnt + PC_W'(1);
   assign active    = (state == RSTD) || (state == RUN) || (state == DRAIN);
   assign abort_hit = active && abort;
   assign capture   = vld_pipe[DUT_LAT];

   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign dut_rst_n = (state != RSTD);
   assign dut_in    = lfsr[IN_W-1:0];
   assign sig       = misr;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RSTD;
         RSTD:    if (cyc_cnt == CC_W'(RST_CYC - 1)) state_nxt = RUN;
         RUN:     if (pat_nxt == PC_W'(NUM_PATTERNS)) state_nxt = DRAIN;
         DRAIN:   if (cyc_cnt == CC_W'(DUT_LAT - 1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (abort_hit) state_nxt = IDLE;
   end

   always_ff @(posedge blif_clk_net) begin
      if (!blif_reset_net) begin
         state    <= IDLE;
         lfsr     <= SEED;
         misr     <= '0;
         pat_cnt  <= '0;
         cyc_cnt  <= '0;
         vld_pipe <= '0;
      end else begin
         state <= state_nxt;
         // cyc_cnt only times RSTD and DRAIN; it restarts on every state change
         if (state_nxt == state && (state == RSTD || state == DRAIN))
            cyc_cnt <= cyc_cnt + CC_W'(1);
         else
            cyc_cnt <= '0;
         if (abort_hit) begin
            vld_pipe <= '0;
         end else begin
            vld_pipe[1] <= (state == RUN);
            for (int i = 2; i <= DUT_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
         end
         if (capture) misr <= misr_nxt;
         if (state == RUN) begin
            lfsr    <= {lfsr[14:0], lfsr_fb};
            pat_cnt <= pat_nxt;
         end
         if (state == IDLE && start) begin
            lfsr    <= SEED;
            misr    <= '0;
            pat_cnt <= '0;
         end
      end
   end

`ifdef PMG_SIG_COMPARE_EN
   // final capture lands on the DONE-entry edge, so compare against the incoming value
   always_ff @(posedge blif_clk_net) begin
      if (!blif_reset_net)
         pass <= 1'b0;
      else if ((state == IDLE && start) || abort_hit)
         pass <= 1'b0;
      else if (state_nxt == DONE && state != DONE)
         pass <= ((capture ? misr_nxt : misr) == GOLDEN_SIG);
   end
`else
   logic unused_golden;
   assign unused_golden = ^GOLDEN_SIG;
   assign pass          = 1'b0;
`endif

endmodule

// File: tb/tb_pattern_merge_bist_ctrl.sv
// Bench for pattern_merge_bist_ctrl with a 2-cycle registered netlist model and a signature scoreboard.
module tb_pattern_merge_bist_ctrl;

   localparam int          IN_W  = 11;
   localparam int          OUT_W = 10;
   localparam int          NP    = 4;
   localparam int          LAT   = 2;
   localparam int          RSTC  = 2;
   localparam logic [15:0] SEED  = 16'hACE1;
   localparam int          RUN_LEN = 1 + RSTC + NP + LAT;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic              dut_rst_n;
   logic [IN_W-1:0]   dut_in;
   logic [OUT_W-1:0]  dut_out;
   logic              busy, done, pass;
   logic [15:0]       sig;

   int n_cmp = 0;
   int n_err = 0;
   bit zero_out = 1'b0;
   logic [15:0] exp_q[$];

   pattern_merge_bist_ctrl #(
      .IN_W(IN_W), .OUT_W(OUT_W), .NUM_PATTERNS(NP), .DUT_LAT(LAT), .RST_CYC(RSTC),
      .SEED(SEED), .GOLDEN_SIG(16'h0000)
   ) dut (
      .blif_clk_net(clk), .blif_reset_net(rst_n), .start(start), .abort(abort),
      .dut_rst_n(dut_rst_n), .dut_in(dut_in), .dut_out(dut_out),
      .busy(busy), .done(done), .sig(sig), .pass(pass)
   );

   always #5 clk = ~clk;

   function automatic logic [OUT_W-1:0] resp(input logic [IN_W-1:0] x);
      return x[9:0] ^ x[10:1] ^ 10'h2A5;
   endfunction

   // netlist model: two register stages, cleared while its reset pin is low
   logic [OUT_W-1:0] p1, p2;
   always @(posedge clk) begin
      if (!dut_rst_n) begin
         p1 <= '0; p2 <= '0;
      end else begin
         p1 <= zero_out ? '0 : resp(dut_in);
         p2 <= p1;
      end
   end
   assign dut_out = p2;

   function automatic logic [15:0] model_sig(input bit zero);
      logic [15:0] l, m;
      l = SEED; m = '0;
      for (int i = 0; i < NP; i++) begin
         m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ (zero ? 16'h0 : {6'h0, resp(l[IN_W-1:0])});
         l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      end
      return m;
   endfunction

   function automatic bit model_pass(input logic [15:0] s);
`ifdef PMG_SIG_COMPARE_EN
      return (s == 16'h0000);
`else
      return (s == 16'h0000) && 1'b0;
`endif
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // drives one run and measures it; expected signature is pushed when start is driven
   task automatic do_run(input bit hold, input int poke_cyc,
                         output int done_cyc, output int rst_lo, output int first_in,
                         output bit mid_drop, output bit busy_after, output bit done_after,
                         output bit pass_at_done, output logic [15:0] sig_at_done);
      int cyc;
      exp_q.push_back(model_sig(zero_out));
      start = 1'b1;
      tick();
      cyc = 1; rst_lo = 0; first_in = -1; done_cyc = -1; mid_drop = 0;
      pass_at_done = 0; sig_at_done = 'x;
      start = hold || (cyc == poke_cyc);
      while (cyc < 200 && done_cyc < 0) begin
         if (!dut_rst_n) rst_lo++;
         else if (rst_lo > 0 && first_in < 0) first_in = int'(dut_in);
         if (done) begin
            done_cyc = cyc; sig_at_done = sig; pass_at_done = pass;
         end else if (!busy) mid_drop = 1;
         if (done_cyc < 0) begin
            tick(); cyc++;
            start = hold || (cyc == poke_cyc);
         end
      end
      tick();
      busy_after = busy; done_after = done;
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 0; abort = 0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (10) tick();
      n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
      n_cmp++; if (done !== 1'b0)      begin n_err++; $display("FAIL reset_done got=%b want=0", done); end
      n_cmp++; if (dut_rst_n !== 1'b1) begin n_err++; $display("FAIL reset_dut_rst_n got=%b want=1", dut_rst_n); end
      n_cmp++; if (sig !== 16'h0000)   begin n_err++; $display("FAIL reset_sig got=%h want=0000", sig); end
      n_cmp++; if (pass !== 1'b0)      begin n_err++; $display("FAIL reset_pass got=%b want=0", pass); end
      n_cmp++; if (dut_in !== SEED[IN_W-1:0]) begin n_err++; $display("FAIL reset_dut_in got=%h want=%h", dut_in, SEED[IN_W-1:0]); end
   endtask

   task automatic test_run();
      int dc, rl, fi; bit md, ba, da, pd; logic [15:0] s, e;
      zero_out = 0;
      do_run(0, -1, dc, rl, fi, md, ba, da, pd, s);
      n_cmp++; if (dc != RUN_LEN) begin n_err++; $display("FAIL run_done_cycle got=%0d want=%0d", dc, RUN_LEN); end
      n_cmp++; if (rl != RSTC) begin n_err++; $display("FAIL run_rst_low got=%0d want=%0d", rl, RSTC); end
      n_cmp++; if (fi != int'(SEED[IN_W-1:0])) begin n_err++; $display("FAIL run_first_in got=%h want=%h", fi, SEED[IN_W-1:0]); end
      n_cmp++; if (md) begin n_err++; $display("FAIL run_busy_gap got=1 want=0"); end
      n_cmp++; if (ba !== 1'b0 || da !== 1'b0) begin n_err++; $display("FAIL run_after_done busy=%b done=%b want=0,0", ba, da); end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      n_cmp++; if (s !== e) begin n_err++; $display("FAIL run_sig got=%h want=%h", s, e); end
      n_cmp++; if (pd !== model_pass(e)) begin n_err++; $display("FAIL run_pass got=%b want=%b", pd, model_pass(e)); end
      n_cmp++; if (sig !== e) begin n_err++; $display("FAIL run_sig_held got=%h want=%h", sig, e); end
   endtask

   task automatic test_zero_out();
      int dc, rl, fi; bit md, ba, da, pd; logic [15:0] s, e;
      zero_out = 1;
      do_run(0, -1, dc, rl, fi, md, ba, da, pd, s);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      n_cmp++; if (s !== e) begin n_err++; $display("FAIL zero_sig got=%h want=%h", s, e); end
      n_cmp++; if (pd !== model_pass(e)) begin n_err++; $display("FAIL zero_pass got=%b want=%b", pd, model_pass(e)); end
      zero_out = 0;
   endtask

   task automatic test_abort();
      int dc, rl, fi, cyc; bit md, ba, da, pd, seen; logic [15:0] s, e;
      start = 1; tick(); start = 0;           // cycle 1 (RSTD)
      repeat (4) tick();                       // cycle 5 = third RUN cycle
      abort = 1; tick(); abort = 0;
      n_cmp++; if (busy !== 1'b0 || dut_rst_n !== 1'b1) begin n_err++; $display("FAIL abort_idle busy=%b dut_rst_n=%b want=0,1", busy, dut_rst_n); end
      n_cmp++; if (pass !== 1'b0) begin n_err++; $display("FAIL abort_pass got=%b want=0", pass); end
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         if (done || busy) seen = 1;
         tick();
      end
      n_cmp++; if (seen) begin n_err++; $display("FAIL abort_no_done got=1 want=0"); end
      // start and abort together in IDLE: start wins
      exp_q.push_back(model_sig(0));
      start = 1; abort = 1; tick(); start = 0; abort = 0;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL start_over_abort busy=%b want=1", busy); end
      cyc = 1;
      while (!done && cyc < 100) begin tick(); cyc++; end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      n_cmp++; if (cyc != RUN_LEN || sig !== e) begin n_err++; $display("FAIL start_over_abort_run cyc=%0d sig=%h want %0d,%h", cyc, sig, RUN_LEN, e); end
      tick();
      do_run(0, -1, dc, rl, fi, md, ba, da, pd, s);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      n_cmp++; if (dc != RUN_LEN || s !== e) begin n_err++; $display("FAIL abort_rerun cyc=%0d sig=%h want %0d,%h", dc, s, RUN_LEN, e); end
   endtask

   task automatic test_start_held();
      int dc, rl, fi; bit md, ba, da, pd; logic [15:0] s, e;
      do_run(1, -1, dc, rl, fi, md, ba, da, pd, s);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      n_cmp++; if (dc != RUN_LEN || md) begin n_err++; $display("FAIL held_run cyc=%0d gap=%b want %0d,0", dc, md, RUN_LEN); end
      n_cmp++; if (s !== e) begin n_err++; $display("FAIL held_sig got=%h want=%h", s, e); end
      tick();
      // start pulsed mid-run is ignored
      do_run(0, 5, dc, rl, fi, md, ba, da, pd, s);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      n_cmp++; if (dc != RUN_LEN || s !== e) begin n_err++; $display("FAIL busy_start cyc=%0d sig=%h want %0d,%h", dc, s, RUN_LEN, e); end
      n_cmp++; if (ba !== 1'b0) begin n_err++; $display("FAIL busy_start_after busy=%b want=0", ba); end
   endtask

   task automatic test_mid_reset();
      start = 1; tick(); start = 0;
      repeat (4) tick();
      rst_n = 0; tick();
      n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL midrst_busy_done busy=%b done=%b want=0,0", busy, done); end
      n_cmp++; if (dut_rst_n !== 1'b1 || sig !== 16'h0000) begin n_err++; $display("FAIL midrst_outputs dut_rst_n=%b sig=%h want=1,0000", dut_rst_n, sig); end
      n_cmp++; if (dut_in !== SEED[IN_W-1:0] || pass !== 1'b0) begin n_err++; $display("FAIL midrst_in_pass dut_in=%h pass=%b want=%h,0", dut_in, pass, SEED[IN_W-1:0]); end
      rst_n = 1; tick();
   endtask

   task automatic test_back_to_back();
      int dc, rl, fi; bit md, ba, da, pd; logic [15:0] s, e;
      do_run(0, -1, dc, rl, fi, md, ba, da, pd, s);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      n_cmp++; if (s !== e) begin n_err++; $display("FAIL b2b_first got=%h want=%h", s, e); end
      zero_out = 1;
      do_run(0, -1, dc, rl, fi, md, ba, da, pd, s);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      n_cmp++; if (s !== e || dc != RUN_LEN) begin n_err++; $display("FAIL b2b_second sig=%h cyc=%0d want %h,%0d", s, dc, e, RUN_LEN); end
      zero_out = 0;
   endtask

   initial begin
      test_reset();
      test_run();
      test_zero_out();
      test_abort();
      test_start_held();
      test_mid_reset();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
